pingpong_rd_sched: RTL

Read-side scheduler for the dual-bank (ping-pong) C2H capture buffer. It runs in `usr_clk`, takes per-bank "filled" toggles from the `clk_50m` write side and alternates full bank reads in strict bank0/bank1 order. Reads are gated by AXI-stream backpressure. When a bank has been read out completely, it is handed back to the writer through a toggle. It drives the RAM read-port enables and address, and a valid/last strobe for the 128-bit packer.

---
 rtl/pingpong_rd_sched.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pingpong_rd_sched.sv
// Read-side scheduler for the ping-pong C2H capture buffer: synchronizes per-bank
// "filled" toggles, reads whole banks in strict 0/1 order and hands them back.
module pingpong_rd_sched #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              usr_clk,
  input  logic              usr_rst_n,
  input  logic              c2h_rst_i,
  input  logic              run_i,
  input  logic              tready_i,
  input  logic [1:0]        wr_done_tog_i,
  output logic [1:0]        rd_done_tog_o,
  output logic              ram0_rd_en_o,
  output logic              ram1_rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              data_valid_o,
  output logic              data_last_o,
  output logic              bank_sel_o,
  output logic              busy_o,
  output logic              overflow_o
);
  // state | meaning
  // IDLE  | run_i low, nothing scheduled
  // WAIT  | waiting for bank nxt to be filled
  // READ  | one read of bank nxt per cycle with tready_i high
  // DONE  | release bank nxt to the writer, swap to the other bank

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [1:0]        sync1_q, sync2_q, tog_seen_q;
  logic [1:0]        tog_edge, clr_full, full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              nxt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        rd_done_tog_q;
  logic              valid_q, last_q, sel_q;
  logic              rd_en, at_last;

  // Synchronizer keeps running through c2h_rst_i so no stale edge appears afterwards.
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tog_seen_q <= '0;
    end else begin
      sync1_q    <= wr_done_tog_i;
      sync2_q    <= sync1_q;
      tog_seen_q <= sync2_q;
    end
  end

  always_comb begin
    tog_edge = sync2_q ^ tog_seen_q;
    clr_full = '0;
    if (state_q == S_DONE) clr_full[nxt_q] = 1'b1;
    // A fill landing on the release cycle is a fresh fill, not an overrun.
    full_d     = (full_q & ~clr_full) | tog_edge;
    overflow_d = overflow_q | (|(tog_edge & full_q & ~clr_full));
    rd_en      = (state_q == S_READ) && tready_i;
    at_last    = (addr_q == LAST_ADDR);
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      state_q       <= S_IDLE;
      full_q        <= '0;
      overflow_q    <= 1'b0;
      nxt_q         <= 1'b0;
      addr_q        <= '0;
      rd_done_tog_q <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      sel_q         <= 1'b0;
    end else if (c2h_rst_i) begin
      state_q    <= S_IDLE;
      full_q     <= '0;
      overflow_q <= 1'b0;
      nxt_q      <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      overflow_q <= overflow_d;
      valid_q    <= rd_en;
      last_q     <= rd_en && at_last;
      sel_q      <= nxt_q;
      case (state_q)
        S_IDLE: if (run_i) state_q <= S_WAIT;
        S_WAIT: begin
          if (full_q[nxt_q])  state_q <= S_READ;
          else if (!run_i)    state_q <= S_IDLE;
        end
        S_READ: begin
          if (tready_i) begin
            if (at_last) state_q <= S_DONE;
            else         addr_q  <= addr_q + ADDR_W'(1);
          end
        end
        S_DONE: begin
          rd_done_tog_q[nxt_q] <= ~rd_done_tog_q[nxt_q];
          addr_q               <= '0;
          nxt_q                <= ~nxt_q;
          state_q              <= S_WAIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram0_rd_en_o  = rd_en & ~nxt_q;
  assign ram1_rd_en_o  = rd_en & nxt_q;
  assign rd_addr_o     = addr_q;
  assign data_valid_o  = valid_q;
  assign data_last_o   = last_q;
  assign bank_sel_o    = sel_q;
  assign busy_o        = (state_q == S_READ) || (state_q == S_DONE);
  assign overflow_o    = overflow_q;
  assign rd_done_tog_o = rd_done_tog_q;

endmodule
